// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, branch conditions and the
// execute-to-memory slot layout.
package cpu_types_pkg;

   localparam int CPU_WORD_W = 32;
   localparam int CPU_REG_AW = 5;

   typedef enum logic [2:0] {
      BR_NONE,
      BR_EQ,
      BR_NE,
      BR_LEZ,
      BR_GTZ,
      BR_LTZ,
      BR_GEZ
   } brtype_t;

   typedef enum logic {
      RUN,
      EXC
   } exmem_state_t;

   typedef struct packed {
      logic [CPU_WORD_W-1:0] result;
      logic [CPU_WORD_W-1:0] store_data;
      logic [CPU_REG_AW-1:0] wsel;
      logic                  regwen;
      logic                  dren;
      logic                  dwen;
   } ex_mem_t;

endpackage

// File: rtl/br_resolve.sv
// Branch condition resolver: decides taken/not-taken from the ALU zero and
// negative flags. Purely combinational so early-branch logic can reuse it.
module br_resolve
   import cpu_types_pkg::*;
(
   input  brtype_t brtype_i,
   input  logic    zero_i,
   input  logic    negative_i,
   output logic    taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (brtype_i)
         BR_EQ:   taken_o = zero_i;
         BR_NE:   taken_o = !zero_i;
         BR_LEZ:  taken_o = negative_i || zero_i;
         BR_GTZ:  taken_o = !negative_i && !zero_i;
         BR_LTZ:  taken_o = negative_i;
         BR_GEZ:  taken_o = !negative_i;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: one-entry result slot with valid/ready toward MEM,
// branch redirect pulse, and overflow trap that holds the stage until acked.
//
// state | meaning
// RUN   | normal flow; accepts when slot empty or being consumed
// EXC   | overflow exception pending; no accepts, slot drains, waits for exc_ack
module ex_mem_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = CPU_WORD_W,
   parameter int REG_AW = CPU_REG_AW
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              flush,
   input  logic [WORD_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_overflow,
   input  logic [WORD_W-1:0] ex_pc,
   input  logic [WORD_W-1:0] ex_br_target,
   input  brtype_t           ex_brtype,
   input  logic              ex_trap_ovf,
   input  logic [REG_AW-1:0] ex_wsel,
   input  logic              ex_regwen,
   input  logic              ex_dren,
   input  logic              ex_dwen,
   input  logic [WORD_W-1:0] ex_store_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [WORD_W-1:0] mem_result,
   output logic [WORD_W-1:0] mem_store_data,
   output logic [REG_AW-1:0] mem_wsel,
   output logic              mem_regwen,
   output logic              mem_dren,
   output logic              mem_dwen,
   output logic              redirect_valid,
   output logic [WORD_W-1:0] redirect_pc,
   output logic              exc_valid,
   output logic [WORD_W-1:0] exc_epc,
   input  logic              exc_ack
);

   exmem_state_t      state_q;
   ex_mem_t           slot_q, slot_d;
   logic              mem_valid_q;
   logic              redir_valid_q;
   logic [WORD_W-1:0] redir_pc_q;
   logic              exc_valid_q;
   logic [WORD_W-1:0] exc_epc_q;

   logic br_taken;
   logic accept;
   logic trap;
   logic load;

   br_resolve u_br_resolve (
      .brtype_i   (ex_brtype),
      .zero_i     (alu_zero),
      .negative_i (alu_negative),
      .taken_o    (br_taken)
   );

   assign ex_ready = (state_q == RUN) && (!mem_valid_q || mem_ready);
   assign accept   = ex_valid && ex_ready && !flush;
   assign trap     = accept && ex_trap_ovf && alu_overflow;
   assign load     = accept && !trap;

   always_comb begin
      slot_d            = slot_q;
      slot_d.result     = alu_out;
      slot_d.store_data = ex_store_data;
      slot_d.wsel       = ex_wsel;
      slot_d.regwen     = ex_regwen;
      slot_d.dren       = ex_dren;
      slot_d.dwen       = ex_dwen;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= RUN;
         slot_q        <= '0;
         mem_valid_q   <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         exc_valid_q   <= 1'b0;
         exc_epc_q     <= '0;
      end else begin
         // A trapping instruction never reaches the slot, so the exception wins over any redirect.
         redir_valid_q <= load && br_taken;
         if (load && br_taken) begin
            redir_pc_q <= ex_br_target;
         end

         if (load) begin
            slot_q      <= slot_d;
            mem_valid_q <= 1'b1;
         end else if (mem_ready) begin
            mem_valid_q <= 1'b0;
         end

         case (state_q)
            RUN: begin
               if (trap) begin
                  exc_valid_q <= 1'b1;
                  exc_epc_q   <= ex_pc;
                  state_q     <= EXC;
               end
            end
            EXC: begin
               if (exc_ack) begin
                  exc_valid_q <= 1'b0;
                  state_q     <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_result     = slot_q.result;
   assign mem_store_data = slot_q.store_data;
   assign mem_wsel       = slot_q.wsel;
   assign mem_regwen     = slot_q.regwen;
   assign mem_dren       = slot_q.dren;
   assign mem_dwen       = slot_q.dwen;
   assign redirect_valid = redir_valid_q;
   assign redirect_pc    = redir_pc_q;
   assign exc_valid      = exc_valid_q;
   assign exc_epc        = exc_epc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios followed by random
// traffic, checked against a behavioural model of the stage.
module tb_ex_mem_stage;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ex_valid, ex_ready, flush;
   logic [31:0] alu_out;
   logic        alu_zero, alu_negative, alu_overflow;
   logic [31:0] ex_pc, ex_br_target;
   brtype_t     ex_brtype;
   logic        ex_trap_ovf;
   logic [4:0]  ex_wsel;
   logic        ex_regwen, ex_dren, ex_dwen;
   logic [31:0] ex_store_data;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_result, mem_store_data;
   logic [4:0]  mem_wsel;
   logic        mem_regwen, mem_dren, mem_dwen;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_valid;
   logic [31:0] exc_epc;
   logic        exc_ack;

   ex_mem_stage #(.WORD_W(32), .REG_AW(5)) dut (
      .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
      .alu_overflow(alu_overflow), .ex_pc(ex_pc), .ex_br_target(ex_br_target),
      .ex_brtype(ex_brtype), .ex_trap_ovf(ex_trap_ovf), .ex_wsel(ex_wsel),
      .ex_regwen(ex_regwen), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
      .ex_store_data(ex_store_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_wsel(mem_wsel),
      .mem_regwen(mem_regwen), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_ack(exc_ack)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] sd;
      logic [7:0]  ctl;
   } exp_slot_t;

   exp_slot_t   q_slot[$];
   logic [31:0] q_redir[$];
   logic [31:0] q_exc[$];

   int n_tests = 0;
   int n_fail  = 0;
   bit m_full  = 1'b0;
   bit m_exc   = 1'b0;
   bit exc_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic report_unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT presented output with no expected entry", name);
   endtask

   // Branch outcome from the signed sense of the ALU result.
   function automatic bit model_taken(input int bt, input bit z, input bit n);
      int v;
      v = z ? 0 : (n ? -1 : 1);
      case (bt)
         1: return v == 0;
         2: return v != 0;
         3: return v <= 0;
         4: return v > 0;
         5: return v < 0;
         6: return v >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_idle();
      ex_valid = 0; flush = 0; alu_out = '0; alu_zero = 0; alu_negative = 0;
      alu_overflow = 0; ex_pc = '0; ex_br_target = '0; ex_brtype = BR_NONE;
      ex_trap_ovf = 0; ex_wsel = '0; ex_regwen = 0; ex_dren = 0; ex_dwen = 0;
      ex_store_data = '0; mem_ready = 0; exc_ack = 0;
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic step();
      bit rdy, acc, trapx, ld, tk, n_full, n_exc;
      #1;
      rdy = !m_exc && (!m_full || mem_ready);
      check("ex_ready", ex_ready, rdy);
      acc   = ex_valid && rdy && !flush;
      trapx = acc && ex_trap_ovf && alu_overflow;
      ld    = acc && !trapx;
      tk    = model_taken(int'(ex_brtype), alu_zero, alu_negative);
      if (ld) q_slot.push_back('{alu_out, ex_store_data, {ex_wsel, ex_regwen, ex_dren, ex_dwen}});
      if (ld && tk) q_redir.push_back(ex_br_target);
      if (trapx) q_exc.push_back(ex_pc);
      n_full = ld ? 1'b1 : (mem_ready ? 1'b0 : m_full);
      n_exc  = trapx ? 1'b1 : ((m_exc && exc_ack) ? 1'b0 : m_exc);
      @(posedge CLK);
      #1;
      m_full = n_full;
      m_exc  = n_exc;
      check("mem_valid", mem_valid, m_full);
      check("exc_valid", exc_valid, m_exc);
      check("redirect_valid", redirect_valid, ld && tk);
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         if (mem_valid && mem_ready) begin
            if (q_slot.size() == 0) report_unexpected("slot_out");
            else begin
               exp_slot_t e;
               e = q_slot.pop_front();
               check("slot_result", mem_result, e.res);
               check("slot_store_data", mem_store_data, e.sd);
               check("slot_ctl", {mem_wsel, mem_regwen, mem_dren, mem_dwen}, e.ctl);
            end
         end
         if (redirect_valid) begin
            if (q_redir.size() == 0) report_unexpected("redirect");
            else check("redirect_pc", redirect_pc, q_redir.pop_front());
         end
         if (exc_valid && !exc_prev) begin
            if (q_exc.size() == 0) report_unexpected("exception");
            else check("exc_epc", exc_epc, q_exc.pop_front());
         end
         exc_prev = exc_valid;
      end
   end

   initial begin
      set_idle();
      RST = 1'b1;
      #1;
      check("rst_mem_valid", mem_valid, 0);
      check("rst_exc_valid", exc_valid, 0);
      check("rst_redirect", redirect_valid, 0);
      check("rst_result", mem_result, 0);
      check("rst_ex_ready", ex_ready, 1);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset mid-stream, between edges
      ex_valid = 1; alu_out = 32'h10; ex_regwen = 1;
      step();
      check("pre_rst_valid", mem_valid, 1);
      check("pre_rst_result", mem_result, 32'h10);
      #2 RST = 1'b1;
      #1;
      check("async_rst_valid", mem_valid, 0);
      check("async_rst_result", mem_result, 0);
      check("async_rst_regwen", mem_regwen, 0);
      q_slot.delete(); q_redir.delete(); q_exc.delete();
      m_full = 0; m_exc = 0; exc_prev = 0;
      RST = 1'b0;
      set_idle();
      @(posedge CLK);
      #1;

      // Back-pressure
      ex_valid = 1; alu_out = 32'h1; mem_ready = 0;
      step();
      check("bp_ready_low", ex_ready, 0);
      alu_out = 32'h2;
      step();
      check("bp_hold", mem_result, 32'h1);
      mem_ready = 1;
      step();
      check("bp_capture", mem_result, 32'h2);
      ex_valid = 0;
      step();

      // Branch taken then not taken
      ex_valid = 1; ex_brtype = BR_NE; alu_zero = 0; ex_br_target = 32'h400; alu_out = 32'h3;
      step();
      check("br_ne_pulse", redirect_valid, 1);
      check("br_ne_pc", redirect_pc, 32'h400);
      ex_valid = 0;
      step();
      check("br_ne_one_cycle", redirect_valid, 0);
      ex_valid = 1; ex_brtype = BR_EQ; ex_br_target = 32'h800;
      step();
      check("br_eq_not_taken", redirect_valid, 0);

      // Overflow trap
      ex_brtype = BR_NONE; ex_trap_ovf = 1; alu_overflow = 1; ex_pc = 32'h88; alu_out = 32'h7;
      step();
      check("trap_exc", exc_valid, 1);
      check("trap_epc", exc_epc, 32'h88);
      check("trap_slot_empty", mem_valid, 0);
      check("trap_ready", ex_ready, 0);
      ex_valid = 0;
      step();
      check("trap_hold", exc_valid, 1);
      exc_ack = 1;
      step();
      check("ack_clear", exc_valid, 0);
      check("ack_ready", ex_ready, 1);
      exc_ack = 0; ex_valid = 1; ex_trap_ovf = 0;
      step();
      check("no_trap_slot", mem_valid, 1);
      check("no_trap_result", mem_result, 32'h7);
      check("no_trap_exc", exc_valid, 0);
      ex_valid = 0;
      step();

      // Flush leaves slot untouched
      mem_ready = 0; ex_valid = 1; alu_out = 32'hAA; ex_brtype = BR_NONE; alu_overflow = 0;
      step();
      flush = 1; alu_out = 32'hBB; ex_brtype = BR_EQ; alu_zero = 1; ex_br_target = 32'h500;
      step();
      check("flush_slot", mem_result, 32'hAA);
      check("flush_valid", mem_valid, 1);
      check("flush_redirect", redirect_valid, 0);
      flush = 0; ex_valid = 0; mem_ready = 1;
      step();

      // Exception wins over taken branch
      ex_valid = 1; ex_brtype = BR_EQ; alu_zero = 1; ex_trap_ovf = 1; alu_overflow = 1;
      ex_pc = 32'h99; ex_br_target = 32'h600;
      step();
      check("prio_exc", exc_valid, 1);
      check("prio_epc", exc_epc, 32'h99);
      check("prio_no_redirect", redirect_valid, 0);
      ex_valid = 0; exc_ack = 1;
      step();
      exc_ack = 0;

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         int v;
         ex_valid      = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 9) == 0);
         alu_out       = $urandom;
         ex_pc         = $urandom;
         ex_br_target  = $urandom;
         ex_store_data = $urandom;
         v             = int'($urandom_range(0, 2));
         alu_zero      = (v == 0);
         alu_negative  = (v == 1);
         alu_overflow  = ($urandom_range(0, 3) == 0);
         ex_trap_ovf   = ($urandom_range(0, 1) == 1);
         ex_brtype     = brtype_t'(3'($urandom_range(0, 6)));
         ex_wsel       = 5'($urandom_range(0, 31));
         ex_regwen     = ($urandom_range(0, 1) == 1);
         ex_dren       = ($urandom_range(0, 1) == 1);
         ex_dwen       = ($urandom_range(0, 1) == 1);
         mem_ready     = ($urandom_range(0, 2) != 0);
         exc_ack       = ($urandom_range(0, 3) == 0);
         step();
      end

      set_idle();
      mem_ready = 1; exc_ack = 1;
      repeat (4) step();
      check("slot_queue_drained", q_slot.size(), 0);
      check("redirect_queue_drained", q_redir.size(), 0);
      check("exc_queue_drained", q_exc.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
